dmem_banked: RTL and testbench
==============================

Name: dmem_banked

Overview:
- Parametrised successor to the 8-bit, 256-entry CPU data memory.
- Adds configurable word width and depth, per-byte write strobes, and a valid/ready request port.
- Adds a pipelined read with configurable latency and a hardware clear sequencer that zeroes the array after reset.
- Sits between the CPU load/store unit and on-chip storage; responses are in order and never back-pressured.

Parameters:
- DW, 8, data width in bits; multiple of 8, 8..64.
- AW, 8, address width (word-addressed).
- DEPTH, 256, number of words; 1 <= DEPTH <= 2**AW.
- RD_LAT, 1, read latency in cycles from accept to rsp_valid; legal values 1..3.
- CLEAR_ON_RST, 1, 1 = zero the array after reset; 0 = skip the clear and go straight to RUN.

Ports:
- clk  in  1  clock; all logic on rising edge.
- rst  in  1  synchronous, active-high reset.
- req_valid  in  1  request present.
- req_ready  out  1  request accepted when req_valid && req_ready.
- req_we  in  1  1 = write, 0 = read.
- req_addr  in  AW  word address.
- req_wdata  in  DW  write data.
- req_be  in  DW/8  byte-lane write enables; ignored on reads.
- rsp_valid  out  1  read data valid; single-cycle pulse per read.
- rsp_rdata  out  DW  read data; 0 whenever rsp_valid=0.
- rsp_err  out  1  error flag qualified by rsp_valid.
- init_done  out  1  high once the clear sequence is complete.

Behaviour:
- Reset values (while rst=1 and in the cycle after): req_ready=0, rsp_valid=0, rsp_rdata=0, rsp_err=0, init_done=0, response pipeline flushed, clear counter=0.
- FSM has two states: CLEAR and RUN.
- CLEAR, entered on rst when CLEAR_ON_RST=1:
  - Writes 0 to address clr_cnt each cycle, clr_cnt=0..DEPTH-1.
  - req_ready=0 throughout.
  - After writing DEPTH-1, moves to RUN; init_done=1 and req_ready=1 from the next cycle.
  - Clear therefore takes exactly DEPTH cycles after rst deasserts.
- With CLEAR_ON_RST=0, the FSM enters RUN the cycle after rst deasserts and the array contents are undefined.
- RUN:
  - req_ready is held at 1, so one request is accepted per cycle with no stalls.
- Write (accepted, req_we=1):
  - For each lane k with req_be[k]=1, mem[addr][8k+7:8k] <= req_wdata[8k+7:8k] at that edge.
  - Lanes with be=0 are unchanged; be=0 in every lane is a legal no-op.
  - A write produces no response.
- Read (accepted, req_we=0):
  - Array is read at the accept edge; data passes through RD_LAT-1 further register stages.
  - rsp_valid pulses exactly RD_LAT cycles after the accept edge.
  - Responses come out in accept order; back-to-back reads give back-to-back rsp_valid.
- Ordering: a read accepted the cycle after a write to the same address returns the new data (write-first ordering by construction; single request port).
- Out of range (req_addr >= DEPTH):
  - Write is dropped, with no array change.
  - Read returns rsp_rdata=0 and rsp_err=1 at the normal latency.
  - Otherwise rsp_err=0, except as set by the optional feature.
- Reset mid-operation: rst asserted in any state aborts CLEAR or RUN, drops in-flight read responses (no rsp_valid is emitted for them), and restarts CLEAR from address 0.
- Array contents under rst: a write in progress in the same cycle as rst is not performed; all other contents are undefined until the clear completes.

Optional Feature:
- Macro: DMEM_PARITY_EN.
- Defined:
  - Each byte lane stores an extra even-parity bit, computed on every write and on clear (clear writes data 0, parity 0).
  - On a read, a parity mismatch in any lane sets rsp_err=1 for that response.
  - Data is returned unmodified; there is no correction.
- Undefined: no parity storage; rsp_err reflects the out-of-range condition only.

Decomposition:
- Package dmem_pkg holds:
  - The state enum (CLEAR, RUN).
  - Function lanes(DW) = DW/8.
  - A parity helper function.
  - Legal-range constants for RD_LAT and DW, checked with elaboration-time assertions.
- One sub-module, dmem_rd_pipe:
  - An RD_LAT-deep valid/data/err shift pipeline with synchronous flush on rst.
  - Instantiated once.
- Array, clear FSM and write-lane logic live in dmem_banked.

Test Plan:
- Clear: DEPTH=16, CLEAR_ON_RST=1; pulse rst for 1 cycle -> req_ready=0 for 16 cycles, then init_done=1; read every address -> rsp_rdata=0, rsp_err=0.
- Byte strobes: DW=32; write 0xAABBCCDD at addr 5 with be=4'b1111, then write 0x00001100 at addr 5 with be=4'b0010; read addr 5 -> 0xAABB11DD.
- Latency/pipelining: RD_LAT=3; preload addr0..3 with 1,2,3,4; issue reads on 4 consecutive cycles -> rsp_valid high on accept+3 through accept+6, data 1,2,3,4 in order.
- Write then read: write 0x5A at addr 7, read addr 7 on the next cycle -> 0x5A after RD_LAT cycles.
- Out of range: DEPTH=200; write 0xFF at addr 210, then read addr 210 -> rsp_rdata=0, rsp_err=1; read addr 199 -> rsp_err=0.
- Reset mid-flight: with 2 reads in flight at RD_LAT=2, assert rst -> no rsp_valid for them; clear restarts at address 0.
  - With DMEM_PARITY_EN defined, force-flip one stored bit at addr 3 and read it -> rsp_err=1, data returned as stored.

Source files
------------

// File: rtl/dmem_pkg.sv
// dmem_pkg: shared types and helpers for the banked CPU data memory.
//   state_t      - controller states (CLEAR sweeps the array to zero, RUN serves requests)
//   lanes()      - number of byte lanes in a data word
//   even_parity()- even-parity bit for one byte lane
//   *_MIN/*_MAX  - legal ranges for DW and RD_LAT, checked at elaboration
package dmem_pkg;

    typedef enum logic {
        CLEAR = 1'b0,
        RUN   = 1'b1
    } state_t;

    localparam int unsigned DW_MIN     = 8;
    localparam int unsigned DW_MAX     = 64;
    localparam int unsigned RD_LAT_MIN = 1;
    localparam int unsigned RD_LAT_MAX = 3;

    function automatic int unsigned lanes(input int unsigned dw);
        return dw / 8;
    endfunction

    // Bit that makes the total number of ones in {byte, bit} even.
    function automatic logic even_parity(input logic [7:0] b);
        return ^b;
    endfunction

endpackage

// File: rtl/dmem_rd_pipe.sv
// dmem_rd_pipe: LAT-deep shift pipeline carrying read valid/data/err.
//   clk, rst              - clock, synchronous active-high flush
//   in_valid/data/err     - read result captured at the accept edge
//   out_valid/data/err    - same result, LAT edges later
// Data and err are zeroed in empty slots so the output data is 0 when invalid.
module dmem_rd_pipe
    import dmem_pkg::*;
#(
    parameter int unsigned DW  = 8,
    parameter int unsigned LAT = 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          in_valid,
    input  logic [DW-1:0] in_data,
    input  logic          in_err,
    output logic          out_valid,
    output logic [DW-1:0] out_data,
    output logic          out_err
);

    if (LAT < RD_LAT_MIN || LAT > RD_LAT_MAX) begin : g_bad_lat
        $error("dmem_rd_pipe: LAT outside legal range");
    end

    logic          valid_q [LAT];
    logic [DW-1:0] data_q  [LAT];
    logic          err_q   [LAT];

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int unsigned i = 0; i < LAT; i++) begin
                valid_q[i] <= 1'b0;
                data_q[i]  <= '0;
                err_q[i]   <= 1'b0;
            end
        end else begin
            valid_q[0] <= in_valid;
            data_q[0]  <= in_valid ? in_data : '0;
            err_q[0]   <= in_valid & in_err;
            for (int unsigned i = 1; i < LAT; i++) begin
                valid_q[i] <= valid_q[i-1];
                data_q[i]  <= data_q[i-1];
                err_q[i]   <= err_q[i-1];
            end
        end
    end

    assign out_valid = valid_q[LAT-1];
    assign out_data  = data_q[LAT-1];
    assign out_err   = err_q[LAT-1];

endmodule

// File: rtl/dmem_banked.sv
// dmem_banked: parametrised CPU data memory with byte strobes, valid/ready
// request port, pipelined reads and a post-reset clear sequencer.
//   clk, rst     - clock, synchronous active-high reset
//   req_*        - request port (valid/ready, we, addr, wdata, be)
//   rsp_valid    - one-cycle pulse per read, RD_LAT cycles after accept
//   rsp_rdata    - read data, 0 when rsp_valid is low
//   rsp_err      - out-of-range (or parity) error, qualified by rsp_valid
//   init_done    - high once the clear sweep has finished
// Optional macro DMEM_PARITY_EN: store an even-parity bit per byte lane and
// flag lane mismatches on reads through rsp_err.
module dmem_banked
    import dmem_pkg::*;
#(
    parameter int unsigned DW           = 8,
    parameter int unsigned AW           = 8,
    parameter int unsigned DEPTH        = 256,
    parameter int unsigned RD_LAT       = 1,
    parameter int unsigned CLEAR_ON_RST = 1
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            req_valid,
    output logic            req_ready,
    input  logic            req_we,
    input  logic [AW-1:0]   req_addr,
    input  logic [DW-1:0]   req_wdata,
    input  logic [DW/8-1:0] req_be,
    output logic            rsp_valid,
    output logic [DW-1:0]   rsp_rdata,
    output logic            rsp_err,
    output logic            init_done
);

    localparam int unsigned NL   = lanes(DW);
    localparam logic [AW-1:0] LAST = AW'(DEPTH - 1);

    if (DW < DW_MIN || DW > DW_MAX || (DW % 8) != 0) begin : g_bad_dw
        $error("dmem_banked: DW outside legal range");
    end
    if (DEPTH < 1 || 64'(DEPTH) > (64'd1 << AW)) begin : g_bad_depth
        $error("dmem_banked: DEPTH outside legal range");
    end

    state_t        state, state_nxt;
    logic [AW-1:0] clr_cnt;
    logic          clr_we;
    logic          accept, in_range, wr_en, rd_en;
    logic [AW-1:0] rd_idx;
    logic [DW-1:0] rd_data;
    logic          par_err;
    logic          pipe_valid, pipe_err;
    logic [DW-1:0] pipe_data;

    logic [DW-1:0] mem [DEPTH];

    // ---------------- controller: state register ----------------
    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= CLEAR;
            clr_cnt <= '0;
        end else begin
            state <= state_nxt;
            if (state == CLEAR) clr_cnt <= clr_cnt + 1'b1;
        end
    end

    // ---------------- controller: next state ----------------
    always_comb begin
        state_nxt = state;
        case (state)
            CLEAR:   if (CLEAR_ON_RST == 0 || clr_cnt == LAST) state_nxt = RUN;
            RUN:     state_nxt = RUN;
            default: state_nxt = CLEAR;
        endcase
    end

    // ---------------- controller: outputs ----------------
    // rst gates everything combinationally so the port reads idle during reset
    // even when the registered state is still RUN.
    always_comb begin
        req_ready = 1'b0;
        init_done = 1'b0;
        clr_we    = 1'b0;
        if (!rst) begin
            case (state)
                CLEAR:   clr_we = (CLEAR_ON_RST != 0);
                RUN: begin
                    req_ready = 1'b1;
                    init_done = 1'b1;
                end
                default: ;
            endcase
        end
    end

    // ---------------- request decode ----------------
    if (64'(DEPTH) == (64'd1 << AW)) begin : g_full_range
        assign in_range = 1'b1;
    end else begin : g_part_range
        assign in_range = (req_addr < AW'(DEPTH));
    end

    assign accept = req_valid & req_ready;
    assign wr_en  = accept & req_we & in_range;
    assign rd_en  = accept & ~req_we;
    assign rd_idx = in_range ? req_addr : '0;

    // ---------------- array and write lanes ----------------
    always_ff @(posedge clk) begin
        if (clr_we) begin
            mem[clr_cnt] <= '0;
        end else if (wr_en) begin
            for (int unsigned k = 0; k < NL; k++) begin
                if (req_be[k]) mem[req_addr][8*k +: 8] <= req_wdata[8*k +: 8];
            end
        end
    end

    assign rd_data = in_range ? mem[rd_idx] : '0;

`ifdef DMEM_PARITY_EN
    logic [NL-1:0] par [DEPTH];

    always_ff @(posedge clk) begin
        if (clr_we) begin
            par[clr_cnt] <= '0;
        end else if (wr_en) begin
            for (int unsigned k = 0; k < NL; k++) begin
                if (req_be[k]) par[req_addr][k] <= even_parity(req_wdata[8*k +: 8]);
            end
        end
    end

    always_comb begin
        par_err = 1'b0;
        if (in_range) begin
            for (int unsigned k = 0; k < NL; k++) begin
                if (even_parity(mem[rd_idx][8*k +: 8]) != par[rd_idx][k]) par_err = 1'b1;
            end
        end
    end
`else
    assign par_err = 1'b0;
`endif

    // ---------------- read pipeline ----------------
    dmem_rd_pipe #(
        .DW  (DW),
        .LAT (RD_LAT)
    ) u_rd_pipe (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (rd_en),
        .in_data   (rd_data),
        .in_err    (~in_range | par_err),
        .out_valid (pipe_valid),
        .out_data  (pipe_data),
        .out_err   (pipe_err)
    );

    assign rsp_valid = pipe_valid & ~rst;
    assign rsp_rdata = rsp_valid ? pipe_data : '0;
    assign rsp_err   = rsp_valid & pipe_err;

endmodule

// File: tb/tb_dmem_banked.sv
// tb_dmem_banked: self-checking bench for dmem_banked (DW=32, DEPTH=200,
// RD_LAT=3). A transaction-level model predicts every cycle's outputs; a set
// of literal expectations pins the model. Define DMEM_PARITY_EN to add the
// parity-corruption case.
module tb_dmem_banked;

    localparam int unsigned DW     = 32;
    localparam int unsigned AW     = 8;
    localparam int unsigned DEPTH  = 200;
    localparam int unsigned RD_LAT = 3;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          req_valid = 1'b0;
    logic          req_ready;
    logic          req_we = 1'b0;
    logic [AW-1:0] req_addr = '0;
    logic [DW-1:0] req_wdata = '0;
    logic [3:0]    req_be = '0;
    logic          rsp_valid;
    logic [DW-1:0] rsp_rdata;
    logic          rsp_err;
    logic          init_done;

    dmem_banked #(
        .DW           (DW),
        .AW           (AW),
        .DEPTH        (DEPTH),
        .RD_LAT       (RD_LAT),
        .CLEAR_ON_RST (1)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_we    (req_we),
        .req_addr  (req_addr),
        .req_wdata (req_wdata),
        .req_be    (req_be),
        .rsp_valid (rsp_valid),
        .rsp_rdata (rsp_rdata),
        .rsp_err   (rsp_err),
        .init_done (init_done)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    typedef struct { int due; logic err; logic [31:0] data; } exp_t;
    typedef struct { int cyc; logic err; logic [31:0] data; } rsp_t;

    logic [31:0] m_mem  [256];
    bit          m_perr [256];
    exp_t        exp_q[$];
    rsp_t        rsp_log[$];
    int          cyc = 0;
    int          since_rst = 0;

    always @(posedge clk) begin
        cyc++;
        if (rst) begin
            since_rst = 0;
            exp_q.delete();
        end else begin
            if (since_rst >= int'(DEPTH) && req_valid) begin
                if (req_we) begin
                    if (req_addr < DEPTH)
                        for (int l = 0; l < 4; l++)
                            if (req_be[l]) m_mem[req_addr][8*l +: 8] = req_wdata[8*l +: 8];
                end else begin
                    exp_q.push_back('{cyc + int'(RD_LAT) - 1,
                                      (req_addr >= DEPTH) || m_perr[req_addr],
                                      (req_addr < DEPTH) ? m_mem[req_addr] : 32'h0});
                end
            end
            since_rst++;
            if (since_rst == int'(DEPTH))
                for (int a = 0; a < 256; a++) begin
                    m_mem[a]  = '0;
                    m_perr[a] = 1'b0;
                end
        end
    end

    // ---------------- per-cycle compare ----------------
    always @(negedge clk) begin
        exp_t e;
        if (rst) begin
            chk("rst_req_ready", req_ready, 0);
            chk("rst_init_done", init_done, 0);
            chk("rst_rsp_valid", rsp_valid, 0);
            chk("rst_rsp_rdata", rsp_rdata, 0);
            chk("rst_rsp_err",   rsp_err,   0);
        end else begin
            chk("req_ready", req_ready, since_rst >= int'(DEPTH));
            chk("init_done", init_done, since_rst >= int'(DEPTH));
            if (exp_q.size() != 0 && exp_q[0].due == cyc) begin
                e = exp_q.pop_front();
                chk("rsp_valid", rsp_valid, 1);
                chk("rsp_rdata", rsp_rdata, e.data);
                chk("rsp_err",   rsp_err,   e.err);
            end else begin
                chk("rsp_valid_idle", rsp_valid, 0);
                chk("rsp_rdata_idle", rsp_rdata, 0);
            end
            if (rsp_valid) rsp_log.push_back('{cyc, rsp_err, rsp_rdata});
        end
    end

    // ---------------- stimulus ----------------
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic req(input logic we, input logic [7:0] a, input logic [31:0] d, input logic [3:0] be);
        req_valid = 1'b1;
        req_we    = we;
        req_addr  = a;
        req_wdata = d;
        req_be    = be;
        step();
    endtask

    task automatic idle(input int n);
        req_valid = 1'b0;
        req_we    = 1'b0;
        repeat (n) step();
    endtask

    task automatic wait_clear(input string name);
        int n = 0;
        while (!req_ready && n < 400) begin
            step();
            n++;
        end
        chk(name, n, DEPTH);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int t0;

        // reset, then clear sweep
        step();
        step();
        rst = 1'b0;
        wait_clear("clear_len");

        // every address reads back zero
        rsp_log.delete();
        for (int a = 0; a < int'(DEPTH); a++) req(1'b0, 8'(a), 32'h0, 4'h0);
        idle(RD_LAT + 2);
        chk("clear_reads", rsp_log.size(), DEPTH);
        chk("clear_last", {rsp_log[DEPTH-1].err, rsp_log[DEPTH-1].data}, 33'h0);

        // byte strobes
        rsp_log.delete();
        req(1'b1, 8'd5, 32'hAABBCCDD, 4'b1111);
        req(1'b1, 8'd5, 32'h00001100, 4'b0010);
        req(1'b0, 8'd5, 32'h0, 4'h0);
        idle(RD_LAT + 2);
        chk("strobe_cnt", rsp_log.size(), 1);
        chk("strobe_data", {rsp_log[0].err, rsp_log[0].data}, {1'b0, 32'hAABB11DD});

        // back-to-back pipelined reads
        for (int a = 0; a < 4; a++) req(1'b1, 8'(a), 32'(a + 1), 4'hF);
        rsp_log.delete();
        t0 = cyc;
        for (int a = 0; a < 4; a++) req(1'b0, 8'(a), 32'h0, 4'h0);
        idle(RD_LAT + 3);
        chk("pipe_cnt", rsp_log.size(), 4);
        for (int i = 0; i < 4; i++) begin
            chk("pipe_data", rsp_log[i].data, 32'(i + 1));
            chk("pipe_cycle", rsp_log[i].cyc - t0, 32'(3 + i));
        end

        // write followed immediately by read; then be=0 no-op
        rsp_log.delete();
        req(1'b1, 8'd7, 32'h0000005A, 4'hF);
        req(1'b0, 8'd7, 32'h0, 4'h0);
        req(1'b1, 8'd9, 32'h12345678, 4'h0);
        req(1'b0, 8'd9, 32'h0, 4'h0);
        idle(RD_LAT + 2);
        chk("wr_rd_cnt", rsp_log.size(), 2);
        chk("wr_rd_data", {rsp_log[0].err, rsp_log[0].data}, {1'b0, 32'h5A});
        chk("be0_data",   {rsp_log[1].err, rsp_log[1].data}, 33'h0);

        // out of range
        rsp_log.delete();
        req(1'b1, 8'd210, 32'hFF, 4'hF);
        req(1'b0, 8'd210, 32'h0, 4'h0);
        req(1'b0, 8'd199, 32'h0, 4'h0);
        idle(RD_LAT + 2);
        chk("oor_cnt", rsp_log.size(), 2);
        chk("oor_210", {rsp_log[0].err, rsp_log[0].data}, {1'b1, 32'h0});
        chk("oor_199", {rsp_log[1].err, rsp_log[1].data}, {1'b0, 32'h0});

`ifdef DMEM_PARITY_EN
        // corrupt one stored bit at addr 3 (holds 4)
        rsp_log.delete();
        dut.mem[3][0] = ~dut.mem[3][0];
        m_mem[3][0]   = ~m_mem[3][0];
        m_perr[3]     = 1'b1;
        req(1'b0, 8'd3, 32'h0, 4'h0);
        idle(RD_LAT + 2);
        chk("parity_err", {rsp_log[0].err, rsp_log[0].data}, {1'b1, 32'h5});
`endif

        // reset with two reads in flight
        rsp_log.delete();
        req(1'b0, 8'd5, 32'h0, 4'h0);
        req(1'b0, 8'd0, 32'h0, 4'h0);
        req_valid = 1'b0;
        rst = 1'b1;
        step();
        rst = 1'b0;
        wait_clear("reclear_len");
        chk("flushed_cnt", rsp_log.size(), 0);
        req(1'b0, 8'd5, 32'h0, 4'h0);
        idle(RD_LAT + 2);
        chk("reclear_data", {rsp_log[0].err, rsp_log[0].data}, 33'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
